// File: rtl/error_accumulator.sv
// error_accumulator: batch statistics over |E| from error_checker.
// Per batch of 2^SHIFT samples it produces a saturating sum of |E|, the mean,
// the maximum with its sample index, and a flag for max exceeding a threshold.
// It also pulses ld_er to clear error_checker's E register at batch start.
module error_accumulator #(
    parameter int WIDTH = 20,
    parameter int SHIFT = 4,
    parameter int ACC_W = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             e_valid,
    input  logic [WIDTH-1:0] E,
    input  logic [WIDTH-1:0] threshold,
    output logic             ld_er,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] sum_out,
    output logic             sat,
    output logic [WIDTH-1:0] mean_out,
    output logic [WIDTH-1:0] max_out,
    output logic [SHIFT-1:0] max_idx,
    output logic             over_thresh
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index of the final sample in a batch (SAMPLES-1 is all ones).
    localparam logic [SHIFT-1:0] LAST_IDX = '1;

    state_t           state_q, state_d;
    logic [SHIFT-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [SHIFT-1:0] idx_q, idx_d;
    logic             over_q, over_d;
    logic             ld_er_q, ld_er_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] abs_e;
    logic [ACC_W:0]   sum_ext;
    logic             max_new;
    logic [WIDTH-1:0] max_post;
    logic [ACC_W-1:0] sum_shr;

    // Magnitude of E and the candidate sum/max for the current sample.
    // The most negative value maps to itself, which is correct as unsigned.
    always_comb begin
        abs_e    = E[WIDTH-1] ? (~E + WIDTH'(1)) : E;
        sum_ext  = {1'b0, sum_q} + (ACC_W+1)'(abs_e);
        max_new  = (abs_e > max_q);
        max_post = max_new ? abs_e : max_q;
    end

    // Next-state and next-result logic; status outputs are registered so
    // they line up with the state they describe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        sat_d   = sat_q;
        max_d   = max_q;
        idx_d   = idx_q;
        over_d  = over_q;
        ld_er_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    ld_er_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    sum_d   = '0;
                    sat_d   = 1'b0;
                    max_d   = '0;
                    idx_d   = '0;
                    over_d  = 1'b0;
                end
            end
            CLEAR: begin
                // E register is being cleared upstream; samples are ignored.
                state_d = ACCUM;
                busy_d  = 1'b1;
                cnt_d   = '0;
                sum_d   = '0;
                sat_d   = 1'b0;
                max_d   = '0;
                idx_d   = '0;
                over_d  = 1'b0;
            end
            ACCUM: begin
                busy_d = 1'b1;
                if (e_valid) begin
                    if (sum_ext[ACC_W]) begin
                        sum_d = '1;
                        sat_d = 1'b1;
                    end else begin
                        sum_d = sum_ext[ACC_W-1:0];
                    end
                    // Strictly greater, so ties keep the earliest index.
                    if (max_new) begin
                        max_d = abs_e;
                        idx_d = cnt_q;
                    end
                    cnt_d = cnt_q + SHIFT'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        over_d  = (max_post > threshold);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            sat_q   <= 1'b0;
            max_q   <= '0;
            idx_q   <= '0;
            over_q  <= 1'b0;
            ld_er_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            sat_q   <= sat_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            over_q  <= over_d;
            ld_er_q <= ld_er_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Mean is the sum scaled down by the batch size, clamped to WIDTH bits.
    always_comb begin
        sum_shr  = sum_q >> SHIFT;
        mean_out = sum_shr[WIDTH-1:0];
        if (|(sum_shr >> WIDTH)) begin
            mean_out = '1;
        end
    end

    assign ld_er       = ld_er_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sum_out     = sum_q;
    assign sat         = sat_q;
    assign max_out     = max_q;
    assign max_idx     = idx_q;
    assign over_thresh = over_q;

endmodule

// File: tb/tb_error_accumulator.sv
// Directed bench for error_accumulator with SHIFT=2. A second instance with a
// narrow accumulator (ACC_W=21) shares the inputs to exercise saturation.
module tb_error_accumulator;

    localparam int WIDTH = 20;
    localparam int SHIFT = 2;

    logic clk = 1'b0;
    logic rst, start, e_valid;
    logic [WIDTH-1:0] E, threshold;

    logic             a_ld_er, a_busy, a_done, a_sat, a_over;
    logic [27:0]      a_sum;
    logic [WIDTH-1:0] a_mean, a_max;
    logic [SHIFT-1:0] a_idx;

    logic             b_ld_er, b_busy, b_done, b_sat, b_over;
    logic [20:0]      b_sum;
    logic [WIDTH-1:0] b_mean, b_max;
    logic [SHIFT-1:0] b_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    error_accumulator #(.WIDTH(WIDTH), .SHIFT(SHIFT), .ACC_W(28)) dut_a (
        .clk(clk), .rst(rst), .start(start), .e_valid(e_valid), .E(E),
        .threshold(threshold), .ld_er(a_ld_er), .busy(a_busy), .done(a_done),
        .sum_out(a_sum), .sat(a_sat), .mean_out(a_mean), .max_out(a_max),
        .max_idx(a_idx), .over_thresh(a_over)
    );

    error_accumulator #(.WIDTH(WIDTH), .SHIFT(SHIFT), .ACC_W(21)) dut_b (
        .clk(clk), .rst(rst), .start(start), .e_valid(e_valid), .E(E),
        .threshold(threshold), .ld_er(b_ld_er), .busy(b_busy), .done(b_done),
        .sum_out(b_sum), .sat(b_sat), .mean_out(b_mean), .max_out(b_max),
        .max_idx(b_idx), .over_thresh(b_over)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [WIDTH-1:0] e);
        E = e;
        e_valid = 1'b1;
        tick();
        e_valid = 1'b0;
    endtask

    task automatic begin_batch();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    initial begin
        // Reset dominates start and e_valid.
        rst = 1'b0; start = 1'b1; e_valid = 1'b1; E = 20'd5; threshold = '0;
        tick();
        tick();
        chk("rst_ld_er", 32'(a_ld_er), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_sum", 32'(a_sum), 32'd0);
        chk("rst_mean", 32'(a_mean), 32'd0);
        chk("rst_max", 32'(a_max), 32'd0);
        chk("rst_idx", 32'(a_idx), 32'd0);
        chk("rst_flags", {30'd0, a_sat, a_over}, 32'd0);
        rst = 1'b1; start = 1'b0; e_valid = 1'b0;
        tick();

        // Basic batch: 5, -3, 10, 0 with threshold 8.
        threshold = 20'd8;
        start = 1'b1;
        tick();
        chk("basic_ld_er_pulse", 32'(a_ld_er), 32'd1);
        chk("basic_busy_clear", 32'(a_busy), 32'd1);
        start = 1'b0;
        tick();
        chk("basic_ld_er_end", 32'(a_ld_er), 32'd0);
        sample(20'd5);
        sample(20'hFFFFD);
        sample(20'd10);
        chk("basic_no_early_done", 32'(a_done), 32'd0);
        sample(20'd0);
        chk("basic_done", 32'(a_done), 32'd1);
        chk("basic_busy_done", 32'(a_busy), 32'd0);
        chk("basic_sum", 32'(a_sum), 32'd18);
        chk("basic_mean", 32'(a_mean), 32'd4);
        chk("basic_max", 32'(a_max), 32'd10);
        chk("basic_idx", 32'(a_idx), 32'd2);
        chk("basic_over", 32'(a_over), 32'd1);
        chk("basic_sat", 32'(a_sat), 32'd0);
        tick();
        chk("basic_done_one_cycle", 32'(a_done), 32'd0);
        chk("basic_sum_hold", 32'(a_sum), 32'd18);

        // Ties and gaps: 7, gap x3 (with a stray start), 7, -7, 2; threshold 7.
        threshold = 20'd7;
        begin_batch();
        sample(20'd7);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("ties_busy_gap", 32'(a_busy), 32'd1);
        chk("ties_no_ld_er", 32'(a_ld_er), 32'd0);
        sample(20'd7);
        sample(20'hFFFF9);
        chk("ties_no_early_done", 32'(a_done), 32'd0);
        sample(20'd2);
        chk("ties_done", 32'(a_done), 32'd1);
        chk("ties_sum", 32'(a_sum), 32'd23);
        chk("ties_max", 32'(a_max), 32'd7);
        chk("ties_idx", 32'(a_idx), 32'd0);
        chk("ties_over", 32'(a_over), 32'd0);
        tick();

        // Saturation: four samples of the most negative value.
        threshold = 20'h7FFFF;
        begin_batch();
        repeat (4) sample(20'h80000);
        chk("sat_b_done", 32'(b_done), 32'd1);
        chk("sat_b_sum", 32'(b_sum), 32'h1FFFFF);
        chk("sat_b_sat", 32'(b_sat), 32'd1);
        chk("sat_b_mean", 32'(b_mean), 32'h7FFFF);
        chk("sat_b_max", 32'(b_max), 32'h80000);
        chk("sat_a_sum", 32'(a_sum), 32'h200000);
        chk("sat_a_sat", 32'(a_sat), 32'd0);
        chk("sat_a_mean", 32'(a_mean), 32'h80000);
        chk("sat_a_over", 32'(a_over), 32'd1);
        tick();

        // Reset after two samples aborts the batch.
        threshold = '0;
        begin_batch();
        sample(20'd1);
        sample(20'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort_sum", 32'(a_sum), 32'd0);
        chk("abort_max", 32'(a_max), 32'd0);
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_done", 32'(a_done), 32'd0);
        tick();
        chk("abort_no_done", 32'(a_done), 32'd0);
        begin_batch();
        repeat (4) sample(20'd1);
        chk("rerun_done", 32'(a_done), 32'd1);
        chk("rerun_sum", 32'(a_sum), 32'd4);
        chk("rerun_mean", 32'(a_mean), 32'd1);
        chk("rerun_max", 32'(a_max), 32'd1);
        chk("rerun_idx", 32'(a_idx), 32'd0);

        // Back-to-back: 1,2,3,4 then start held from the done cycle.
        tick();
        threshold = 20'd3;
        begin_batch();
        sample(20'd1);
        sample(20'd2);
        sample(20'd3);
        sample(20'd4);
        chk("b2b_done", 32'(a_done), 32'd1);
        chk("b2b_sum", 32'(a_sum), 32'd10);
        chk("b2b_idx", 32'(a_idx), 32'd3);
        chk("b2b_over", 32'(a_over), 32'd1);
        start = 1'b1;
        tick();
        chk("b2b_idle_ld_er", 32'(a_ld_er), 32'd0);
        chk("b2b_idle_busy", 32'(a_busy), 32'd0);
        chk("b2b_sum_hold", 32'(a_sum), 32'd10);
        tick();
        chk("b2b_clear_ld_er", 32'(a_ld_er), 32'd1);
        chk("b2b_clear_busy", 32'(a_busy), 32'd1);
        start = 1'b0;
        tick();
        chk("b2b_sum_cleared", 32'(a_sum), 32'd0);
        chk("b2b_max_cleared", 32'(a_max), 32'd0);
        chk("b2b_idx_cleared", 32'(a_idx), 32'd0);
        chk("b2b_over_cleared", 32'(a_over), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
